// File: rtl/aoc15_5_2_pkg.sv
// Shared constants, types and helpers for the AoC 2015 day 5 part 2 JTAG solver.
package aoc15_5_2_pkg;

  localparam int unsigned DEFAULT_RESULT_WIDTH = 16;
  localparam int unsigned NUM_LETTERS          = 26;
  localparam int unsigned NUM_PAIRS            = NUM_LETTERS * NUM_LETTERS;
  localparam int unsigned PAIR_W               = 10;

  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] ASCII_A = 8'h61;
  localparam logic [7:0] ASCII_Z = 8'h7A;

  typedef logic [4:0] letter_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } byte_beat_t;

  typedef enum logic [1:0] {
    UP_IDLE,
    UP_WAIT,
    UP_FLUSH,
    UP_DONE
  } up_state_t;

  // Flat index of an ordered letter pair into the seen vector.
  function automatic logic [PAIR_W-1:0] pair_idx(letter_t p1, letter_t p2);
    return PAIR_W'(p1) * PAIR_W'(NUM_LETTERS) + PAIR_W'(p2);
  endfunction

endpackage

// File: rtl/aoc15_5_2_nice_counter_checker.sv
// Per-line nice checker: tracks the last two letters, a seen-pair vector and the two rule flags.
module nice_line_checker
  import aoc15_5_2_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       letter_valid,
  input  logic [4:0] letter,
  input  logic       eol,
  output logic       nice_c
);

  letter_t              prev1;
  letter_t              prev2;
  logic                 prev1_valid;
  logic                 prev2_valid;
  logic [NUM_PAIRS-1:0] seen;
  logic                 flag_a;
  logic                 flag_b;

  assign nice_c = flag_a & flag_b;

  // Pair (prev2,prev1) is inserted only after the lookup, so an overlapping "aaa" never matches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev1       <= '0;
      prev2       <= '0;
      prev1_valid <= 1'b0;
      prev2_valid <= 1'b0;
      seen        <= '0;
      flag_a      <= 1'b0;
      flag_b      <= 1'b0;
    end else if (clear || eol) begin
      prev1       <= '0;
      prev2       <= '0;
      prev1_valid <= 1'b0;
      prev2_valid <= 1'b0;
      seen        <= '0;
      flag_a      <= 1'b0;
      flag_b      <= 1'b0;
    end else if (letter_valid) begin
      if (prev2_valid && (letter == prev2)) begin
        flag_b <= 1'b1;
      end
      if (prev1_valid && seen[pair_idx(prev1, letter)]) begin
        flag_a <= 1'b1;
      end
      if (prev2_valid) begin
        seen[pair_idx(prev2, prev1)] <= 1'b1;
      end
      prev2       <= prev1;
      prev2_valid <= prev1_valid;
      prev1       <= letter;
      prev1_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/aoc15_5_2_nice_counter.sv
// JTAG USER-DR front end: deserializes uploaded text, counts nice lines, serves the count on readout.
module aoc15_5_2_nice_counter
  import aoc15_5_2_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = DEFAULT_RESULT_WIDTH
) (
  input  logic tck,
  input  logic rst_n,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  input  logic test_logic_reset,
  input  logic ir_is_user,
  input  logic run_test_idle,
  input  logic capture_dr,
  input  logic shift_dr,
  input  logic update_dr
);

  logic                    unused_ok;
  logic                    dr_cap;
  logic                    dr_shift;
  logic                    dr_update;
  logic                    dummy_pending;
  logic [2:0]              bit_cnt;
  logic [7:0]              byte_sr;
  byte_beat_t              beat;
  logic                    byte_seen;
  logic                    byte_done_c;
  logic                    is_letter_c;
  logic                    is_lf_c;
  logic                    flush_c;
  logic                    eol_c;
  logic                    nice_c;
  logic                    done;
  up_state_t               state;
  up_state_t               state_next;
  logic [RESULT_WIDTH-1:0] count;
  logic [RESULT_WIDTH-1:0] rd_sr;

  assign unused_ok = ^{tms, run_test_idle};

  assign dr_cap      = ir_is_user & capture_dr;
  assign dr_shift    = ir_is_user & shift_dr & ~capture_dr;
  assign dr_update   = ir_is_user & update_dr;
  assign byte_done_c = dr_shift & ~dummy_pending & (bit_cnt == 3'd7);

  // Deserializer: first shifted bit after capture is the DAP bypass bit, then bytes LSB first.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      dummy_pending <= 1'b0;
      bit_cnt       <= '0;
      byte_sr       <= '0;
      beat          <= '0;
      byte_seen     <= 1'b0;
    end else if (test_logic_reset) begin
      dummy_pending <= 1'b0;
      bit_cnt       <= '0;
      byte_sr       <= '0;
      beat          <= '0;
      byte_seen     <= 1'b0;
    end else begin
      beat.valid <= byte_done_c;
      if (byte_done_c) begin
        beat.data <= {tdi, byte_sr[7:1]};
        byte_seen <= 1'b1;
      end
      if (dr_cap) begin
        dummy_pending <= 1'b1;
        bit_cnt       <= '0;
      end else if (dr_shift) begin
        if (dummy_pending) begin
          dummy_pending <= 1'b0;
        end else begin
          byte_sr <= {tdi, byte_sr[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  assign is_letter_c = beat.valid && (beat.data >= ASCII_A) && (beat.data <= ASCII_Z);
  assign is_lf_c     = beat.valid && (beat.data == LF);
  assign eol_c       = is_lf_c | flush_c;

  nice_line_checker u_checker (
    .clk          (tck),
    .rst_n        (rst_n),
    .clear        (test_logic_reset),
    .letter_valid (is_letter_c),
    .letter       (5'(beat.data - ASCII_A)),
    .eol          (eol_c),
    .nice_c       (nice_c)
  );

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state <= UP_IDLE;
    end else if (test_logic_reset) begin
      state <= UP_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // WAIT lets a byte completing alongside update_dr reach the checker flags before the flush.
  always_comb begin
    state_next = state;
    flush_c    = 1'b0;
    case (state)
      UP_IDLE: begin
        if (dr_update && (byte_seen || byte_done_c)) begin
          state_next = UP_WAIT;
        end
      end
      UP_WAIT:  state_next = UP_FLUSH;
      UP_FLUSH: begin
        flush_c    = 1'b1;
        state_next = UP_DONE;
      end
      UP_DONE:  state_next = UP_DONE;
      default:  state_next = UP_IDLE;
    endcase
  end

  assign done = (state == UP_DONE);

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (test_logic_reset) begin
      count <= '0;
    end else if (eol_c && nice_c) begin
      count <= count + RESULT_WIDTH'(1);
    end
  end

  // Readout DR: capture has priority over shift.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      rd_sr <= '0;
    end else if (test_logic_reset) begin
      rd_sr <= '0;
    end else if (dr_cap) begin
      rd_sr <= done ? count : '0;
    end else if (dr_shift) begin
      rd_sr <= rd_sr >> 1;
    end
  end

  assign tdo = rd_sr[0];

endmodule

// File: tb/tb_aoc15_5_2_nice_counter.sv
// Bench for the nice-line counter: drives decoded TAP states, compares against a string-level model.
module tb_aoc15_5_2_nice_counter;

  typedef byte unsigned bq_t[$];

  logic tck = 1'b0;
  logic rst_n = 1'b0;
  logic tms = 1'b0;
  logic tdi = 1'b0;
  logic tdo;
  logic test_logic_reset = 1'b0;
  logic ir_is_user = 1'b0;
  logic run_test_idle = 1'b0;
  logic capture_dr = 1'b0;
  logic shift_dr = 1'b0;
  logic update_dr = 1'b0;

  int checks = 0;
  int failures = 0;

  aoc15_5_2_nice_counter #(.RESULT_WIDTH(16)) dut (
    .tck              (tck),
    .rst_n            (rst_n),
    .tms              (tms),
    .tdi              (tdi),
    .tdo              (tdo),
    .test_logic_reset (test_logic_reset),
    .ir_is_user       (ir_is_user),
    .run_test_idle    (run_test_idle),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr)
  );

  always #5 tck = ~tck;

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Nice test on the letters of one line, straight from the two rules.
  function automatic bit line_nice(input bq_t l);
    bit a = 1'b0;
    bit b = 1'b0;
    for (int i = 0; i + 2 < l.size(); i++)
      if (l[i] == l[i+2]) b = 1'b1;
    for (int i = 0; i + 1 < l.size(); i++)
      for (int j = i + 2; j + 1 < l.size(); j++)
        if (l[i] == l[j] && l[i+1] == l[j+1]) a = 1'b1;
    return a && b;
  endfunction

  function automatic logic [15:0] model_count(input bq_t q);
    bq_t cur;
    int unsigned cnt = 0;
    foreach (q[i]) begin
      if (q[i] == 8'h0A) begin
        if (line_nice(cur)) cnt++;
        cur.delete();
      end else if (q[i] >= 8'h61 && q[i] <= 8'h7A) begin
        cur.push_back(q[i]);
      end
    end
    if (line_nice(cur)) cnt++;
    return 16'(cnt);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic upload(input bq_t q);
    ir_is_user = 1'b1;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr   = 1'b1;
    tdi        = 1'($urandom);
    tick();
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        tdi = q[i][b];
        tick();
      end
    end
    shift_dr  = 1'b0;
    tdi       = 1'b0;
    tick();
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic readout(output logic [15:0] v);
    ir_is_user = 1'b1;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr   = 1'b1;
    tdi        = 1'b0;
    for (int j = 0; j < 16; j++) begin
      v[j] = tdo;
      tick();
    end
    shift_dr  = 1'b0;
    tick();
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
    tick();
  endtask

  task automatic run_case(input string tag, input bq_t q, input logic [15:0] exp);
    logic [15:0] v;
    do_reset();
    upload(q);
    readout(v);
    check(tag, v, exp);
  endtask

  function automatic bq_t rand_text();
    bq_t q;
    int n_lines = $urandom_range(1, 6);
    for (int l = 0; l < n_lines; l++) begin
      int len = $urandom_range(0, 14);
      for (int k = 0; k < len; k++) begin
        int r = $urandom_range(0, 19);
        if (r == 0)      q.push_back(8'h0D);
        else if (r == 1) q.push_back(8'h2E);
        else             q.push_back(8'(8'h61 + $urandom_range(0, 2)));
      end
      if (l < n_lines - 1 || $urandom_range(0, 1) == 1) q.push_back(8'h0A);
    end
    if (q.size() == 0) q.push_back(8'h61);
    return q;
  endfunction

  initial begin
    logic [15:0] v;
    bq_t big;
    bq_t rq;

    repeat (2) tick();
    check("reset_tdo", {15'd0, tdo}, 16'h0000);
    rst_n = 1'b1;
    tick();
    readout(v);
    check("pre_upload", v, 16'h0000);

    run_case("example", str2q("qjhvhtzxzqqjkmpb\nxxyxx\nuurcxstgmygtbstg\nieodomkazucvgmuy\n"), 16'd2);
    run_case("overlap", str2q("aaa\naaaa\n"), 16'd1);
    run_case("no_trailing_lf", str2q("xyxy"), 16'd1);
    run_case("cr_ignored", str2q("ab\r\nxyxy\r\n"), 16'd1);

    // Reset asserted in the middle of a shift, then a clean upload.
    do_reset();
    ir_is_user = 1'b1;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr   = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tdi = 1'($urandom);
      tick();
    end
    rst_n = 1'b0;
    #2;
    check("mid_reset_tdo", {15'd0, tdo}, 16'h0000);
    shift_dr = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    upload(str2q("xxyxx\n"));
    readout(v);
    check("after_mid_reset", v, 16'd1);

    for (int i = 0; i < 1000; i++) begin
      big.push_back(8'h61); big.push_back(8'h61);
      big.push_back(8'h61); big.push_back(8'h61);
      big.push_back(8'h0A);
    end
    run_case("thousand_aaaa", big, 16'h03e8);

    test_logic_reset = 1'b1;
    tick();
    test_logic_reset = 1'b0;
    tick();
    check("tlr_tdo", {15'd0, tdo}, 16'h0000);
    readout(v);
    check("tlr_readout", v, 16'h0000);

    for (int t = 0; t < 6; t++) begin
      rq = rand_text();
      run_case($sformatf("random_%0d", t), rq, model_count(rq));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
